spi_cfg_master: RTL

SPI mode-0 master that serialises one 32-bit tuner configuration word (gain + NCO phase increment) onto SCK/MOSI/CS.
- Drives the radio's SPI configuration receiver from an on-chip controller or a test harness in the same CLK domain.
- Frame format: MSB first; bits[31:30]=2'b00, [29:26]=gain, [25:0]=phase_inc.
- Timing is paced so a receiver with 3-flop input synchronisers samples every bit reliably.

---
 rtl/spi_cfg_master_pkg.sv | 46 ++++
 rtl/spi_cfg_master_if.sv | 36 +++
 rtl/spi_cfg_master_sck_div.sv | 41 ++++
 rtl/spi_cfg_master.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cfg_pkg
//  Purpose  : Shared widths, field offsets, reset defaults, FSM state type
//             and the frame packing helper for the SPI tuner-config master.
//  Contents : WORD_W / PHASE_INC_W / GAIN_W  - field widths
//             GAIN_LSB / PHASE_LSB           - bit offsets inside the frame
//             PHASE_INC_RST / GAIN_RST       - power-on tuner settings
//             state_t                        - master FSM states
//             pack_word()                    - {2'b00, gain, phase_inc}
//  Revision : 1.0 - initial release
// ============================================================================
package spi_cfg_pkg;

    localparam int WORD_W      = 32;
    localparam int PHASE_INC_W = 26;
    localparam int GAIN_W      = 4;

    localparam int GAIN_LSB    = 26;
    localparam int PHASE_LSB   = 0;

    localparam logic [PHASE_INC_W-1:0] PHASE_INC_RST = 26'h1312eb;
    localparam logic [GAIN_W-1:0]      GAIN_RST      = 4'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Bits [31:30] are reserved and always sent as zero.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [GAIN_W-1:0]      gain,
        input logic [PHASE_INC_W-1:0] phase_inc
    );
        logic [WORD_W-1:0] w_word;
        w_word                            = '0;
        w_word[GAIN_LSB +: GAIN_W]        = gain;
        w_word[PHASE_LSB +: PHASE_INC_W]  = phase_inc;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cfg_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cfg_master_if
//  Purpose  : Bundles the request handshake and the SPI pins of the tuner
//             configuration master.
//  Signals  : start, phase_inc, gain   - request side (into the master)
//             busy, done               - status (out of the master)
//             SCK, MOSI, CS            - SPI mode-0 pins (out of the master)
//  Modports : master - the SPI master itself
//             slave  - the controller / harness driving it
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_cfg_master_if;
    import spi_cfg_pkg::*;

    logic                   start;
    logic [PHASE_INC_W-1:0] phase_inc;
    logic [GAIN_W-1:0]      gain;
    logic                   busy;
    logic                   done;
    logic                   SCK;
    logic                   MOSI;
    logic                   CS;

    modport master (
        input  start, phase_inc, gain,
        output busy, done, SCK, MOSI, CS
    );

    modport slave (
        output start, phase_inc, gain,
        input  busy, done, SCK, MOSI, CS
    );

endinterface
`default_nettype wire

// File: rtl/spi_cfg_master_sck_div.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sck_div
//  Purpose  : SCK half-period tick generator. Counts CLK cycles while not
//             cleared and pulses o_tick on the last cycle of every CLK_DIV
//             cycle window; the master toggles SCK on that tick.
//  Ports    : CLK     - system clock
//             RSTb    - asynchronous active-low reset
//             i_clr   - synchronous clear, holds the count at zero
//             o_tick  - one-cycle half-period tick (never while cleared)
//  Params   : CLK_DIV - CLK cycles per SCK half-period
//  Revision : 1.0 - initial release
// ============================================================================
module spi_sck_div #(
    parameter int CLK_DIV = 4
) (
    input  wire logic CLK,
    input  wire logic RSTb,
    input  wire logic i_clr,
    output logic      o_tick
);

    localparam int                c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_tick = !i_clr && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_cfg_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cfg_master
//  Purpose  : SPI mode-0 master sending one 32-bit tuner configuration word
//             {2'b00, gain[3:0], phase_inc[25:0]} MSB first. Pacing leaves
//             enough CLK cycles per SCK phase for a receiver that runs its
//             inputs through 3-flop synchronisers.
//  Ports    : CLK            - system clock
//             RSTb           - asynchronous active-low reset
//             bus (master)   - start/gain/phase_inc in; busy/done/SCK/MOSI/CS
//  Params   : CLK_DIV  (>=4) - CLK cycles per SCK half-period
//             CS_SETUP (>=1) - CS fall to first SCK rise
//             CS_HOLD  (>=1) - last SCK fall to CS rise
//             CS_GAP   (>=2) - CS high cycles before busy drops
//  Option   : SPI_CFG_AUTOSEND_EN - when defined, any change of gain or
//             phase_inc against the last-sent copy triggers a frame.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_cfg_master
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input  wire logic         CLK,
    input  wire logic         RSTb,
    spi_cfg_master_if.master  bus
);

    // One shared counter times SETUP, HOLD and GAP; size it for the longest.
    localparam int c_TMAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_TMAX    = (c_TMAX_SH > CS_GAP) ? c_TMAX_SH : CS_GAP;
    localparam int c_TCNT_W  = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_TCNT_W-1:0] c_SETUP_LAST = c_TCNT_W'(CS_SETUP - 1);
    localparam logic [c_TCNT_W-1:0] c_HOLD_LAST  = c_TCNT_W'(CS_HOLD - 1);
    localparam logic [c_TCNT_W-1:0] c_GAP_LAST   = c_TCNT_W'(CS_GAP - 1);
    localparam logic [5:0]          c_LAST_BIT   = 6'd31;

    state_t              r_state,  w_state_nxt;
    logic [WORD_W-1:0]   r_shreg,  w_shreg_nxt;
    logic [5:0]          r_bitcnt, w_bitcnt_nxt;
    logic [c_TCNT_W-1:0] r_tcnt,   w_tcnt_nxt;
    logic                r_sck,    w_sck_nxt;
    logic                r_mosi,   w_mosi_nxt;
    logic                r_cs,     w_cs_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_done,   w_done_nxt;

    logic                w_tick;
    logic                w_div_clr;
    logic                w_req;
    logic                w_accept;
    logic [WORD_W-1:0]   w_word;

    assign w_word   = pack_word(bus.gain, bus.phase_inc);
    assign w_accept = (r_state == IDLE) && w_req;

`ifdef SPI_CFG_AUTOSEND_EN
    // Copy of what was last put on the wire; a mismatch means the tuner is
    // stale and a frame is requested. Updated only when a frame is accepted,
    // so a change made while busy is picked up once the FSM is back in IDLE.
    logic [GAIN_W-1:0]      r_last_gain;
    logic [PHASE_INC_W-1:0] r_last_phase;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_last_gain  <= GAIN_RST;
            r_last_phase <= PHASE_INC_RST;
        end else if (w_accept) begin
            r_last_gain  <= bus.gain;
            r_last_phase <= bus.phase_inc;
        end
    end

    assign w_req = bus.start
                || (bus.gain      != r_last_gain)
                || (bus.phase_inc != r_last_phase);
`else
    assign w_req = bus.start;
`endif

    // The divider only runs in SHIFT, so the first tick lands exactly
    // CLK_DIV cycles after the first SCK rise.
    assign w_div_clr = (r_state != SHIFT);

    spi_sck_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_div (
        .CLK    (CLK),
        .RSTb   (RSTb),
        .i_clr  (w_div_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_tcnt   <= '0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_cs     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_sck    <= w_sck_nxt;
            r_mosi   <= w_mosi_nxt;
            r_cs     <= w_cs_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_tcnt_nxt   = r_tcnt;
        w_sck_nxt    = r_sck;
        w_mosi_nxt   = r_mosi;
        w_cs_nxt     = r_cs;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // CS falls with the MSB already on MOSI.
                    w_state_nxt  = SETUP;
                    w_shreg_nxt  = w_word;
                    w_mosi_nxt   = w_word[WORD_W-1];
                    w_sck_nxt    = 1'b0;
                    w_cs_nxt     = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_bitcnt_nxt = '0;
                    w_tcnt_nxt   = '0;
                end
            end

            SETUP: begin
                if (r_tcnt == c_SETUP_LAST) begin
                    w_state_nxt = SHIFT;
                    w_sck_nxt   = 1'b1;
                    w_tcnt_nxt  = '0;
                end else begin
                    w_tcnt_nxt  = r_tcnt + c_TCNT_W'(1);
                end
            end

            SHIFT: begin
                if (w_tick) begin
                    if (!r_sck) begin
                        w_sck_nxt = 1'b1;
                    end else begin
                        w_sck_nxt = 1'b0;
                        if (r_bitcnt == c_LAST_BIT) begin
                            // 32nd fall: park MOSI low, bit counter stays at 31.
                            w_mosi_nxt  = 1'b0;
                            w_state_nxt = HOLD;
                            w_tcnt_nxt  = '0;
                        end else begin
                            w_shreg_nxt  = r_shreg << 1;
                            w_mosi_nxt   = r_shreg[WORD_W-2];
                            w_bitcnt_nxt = r_bitcnt + 6'd1;
                        end
                    end
                end
            end

            HOLD: begin
                if (r_tcnt == c_HOLD_LAST) begin
                    w_cs_nxt    = 1'b1;
                    w_state_nxt = GAP;
                    w_tcnt_nxt  = '0;
                end else begin
                    w_tcnt_nxt  = r_tcnt + c_TCNT_W'(1);
                end
            end

            GAP: begin
                // The receiver commits its word during this CS-high window.
                if (r_tcnt == c_GAP_LAST) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                    w_tcnt_nxt  = '0;
                end else begin
                    w_tcnt_nxt  = r_tcnt + c_TCNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cs_nxt    = 1'b1;
                w_sck_nxt   = 1'b0;
                w_mosi_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.SCK  = r_sck;
    assign bus.MOSI = r_mosi;
    assign bus.CS   = r_cs;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire
